// File: rtl/vdp_cpu_port.sv
// CPU port controller for the TMS9918-style VDP: control/data ports, R0-R7, status, VRAM sequencing.
// Build option: VDP_STATUS_CLR_EN makes control-port reads clear F, 5S and C.
module vdp_cpu_port #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_en,
  input  logic              port_sel,
  input  logic              wr,
  input  logic              rd,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              vram_req,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  input  logic              vram_gnt,
  input  logic [7:0]        vram_rdata,
  input  logic              vblank_set,
  input  logic              coll_set,
  input  logic              fifth_set,
  input  logic [4:0]        fifth_num,
  output logic [63:0]       regs,
  output logic              int_n,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {
    V_IDLE,
    V_REQ,
    V_CAP
  } vstate_t;

  vstate_t           vstate;
  logic              phase;
  logic [7:0]        latch;
  logic [7:0]        rdlatch;
  logic [7:0]        r [8];
  logic [ADDR_W-1:0] addr;
  logic              dirty;
  logic              pend_rd;
  logic              vwe;
  logic [ADDR_W-1:0] vaddr;
  logic [7:0]        wdata;
  logic              f;
  logic              s5;
  logic              c;
  logic [4:0]        fifth;

  logic              ctl_wr;
  logic              ctl_rd;
  logic              dat_wr;
  logic              dat_rd;
  logic              dat_acc;
  logic              reg_we;
  logic              addr_we;
  logic              ra_req;
  logic              stat_clr;
  logic              done;
  logic              rd_next;
  logic              f_nxt;
  logic              s5_nxt;
  logic              c_nxt;
  logic [7:0]        r1_nxt;
  logic [13:0]       set_addr;
  logic [ADDR_W-1:0] new_addr;
  logic [7:0]        status;

  assign ctl_wr  = io_en & wr & port_sel;
  assign ctl_rd  = io_en & rd & ~wr & port_sel;
  assign dat_wr  = io_en & wr & ~port_sel;
  assign dat_rd  = io_en & rd & ~wr & ~port_sel;
  assign dat_acc = dat_wr | dat_rd;

  assign reg_we  = ctl_wr & phase & din[7] & (din[5:3] == 3'd0);
  assign addr_we = ctl_wr & phase & ~din[7];
  assign ra_req  = addr_we & ~din[6];

  assign set_addr = {din[5:0], latch};
  assign new_addr = ADDR_W'(set_addr);

`ifdef VDP_STATUS_CLR_EN
  assign stat_clr = ctl_rd;
`else
  assign stat_clr = 1'b0;
`endif

  // set pulses win over a clearing status read in the same cycle
  assign f_nxt  = vblank_set | (f & ~stat_clr);
  assign s5_nxt = fifth_set | (s5 & ~stat_clr);
  assign c_nxt  = coll_set | (c & ~stat_clr);
  assign r1_nxt = (reg_we && din[2:0] == 3'd1) ? latch : r[1];

  assign done = (vstate == V_REQ && vram_gnt && vwe) ||
                (vstate == V_CAP);
  assign rd_next = ra_req | (pend_rd & ~addr_we);

  assign status = {f, s5, c, s5 ? fifth : 5'h1F};
  assign dout   = port_sel ? status : rdlatch;

  assign busy       = (vstate != V_IDLE);
  assign vram_req   = (vstate == V_REQ);
  assign vram_we    = vwe;
  assign vram_addr  = vaddr;
  assign vram_wdata = wdata;

  for (genvar i = 0; i < 8; i++) begin : g_regs
    assign regs[8*i +: 8] = r[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vstate  <= V_IDLE;
      phase   <= 1'b0;
      latch   <= 8'h00;
      rdlatch <= 8'h00;
      for (int i = 0; i < 8; i++) r[i] <= 8'h00;
      addr    <= '0;
      dirty   <= 1'b0;
      pend_rd <= 1'b0;
      vwe     <= 1'b0;
      vaddr   <= '0;
      wdata   <= 8'h00;
      f       <= 1'b0;
      s5      <= 1'b0;
      c       <= 1'b0;
      fifth   <= 5'h00;
      int_n   <= 1'b1;
      overrun <= 1'b0;
    end else begin
      if (ctl_wr) phase <= ~phase;
      else if (dat_acc | ctl_rd) phase <= 1'b0;
      if (ctl_wr & ~phase) latch <= din;
      if (reg_we) r[din[2:0]] <= latch;

      f     <= f_nxt;
      s5    <= s5_nxt;
      c     <= c_nxt;
      int_n <= ~(f_nxt & r1_nxt[5]);
      if (fifth_set) fifth <= fifth_num;
      if (dat_acc & busy) overrun <= 1'b1;

      // an address set mid-access replaces the pending increment
      if (addr_we) addr <= new_addr;
      else if (done & ~dirty) addr <= addr + ADDR_W'(1);
      dirty   <= ~done & (dirty | (addr_we & busy));
      pend_rd <= ~done & busy & rd_next;

      unique case (vstate)
        V_IDLE: begin
          if (dat_wr) begin
            vstate  <= V_REQ;
            vwe     <= 1'b1;
            vaddr   <= addr;
            wdata   <= din;
            rdlatch <= din;
          end else if (dat_rd) begin
            vstate <= V_REQ;
            vwe    <= 1'b0;
            vaddr  <= addr;
          end else if (ra_req) begin
            vstate <= V_REQ;
            vwe    <= 1'b0;
            vaddr  <= new_addr;
          end
        end
        V_REQ: begin
          if (vram_gnt & ~vwe) vstate <= V_CAP;
        end
        V_CAP: begin
          rdlatch <= vram_rdata;
        end
        default: vstate <= V_IDLE;
      endcase

      if (done) begin
        vwe <= 1'b0;
        if (rd_next) begin
          vstate <= V_REQ;
          vaddr  <= addr_we ? new_addr : addr;
        end else begin
          vstate <= V_IDLE;
        end
      end
    end
  end

endmodule
